// File: rtl/axilite_csr_read_data_if.sv
// AXI4-Lite read-channel (AR/R) bundle shared by the CSR read responder and its masters.
interface axilite_csr_read_data_if #(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_SIZE-1:0]  araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axilite_csr_read_data.sv
// AXI4-Lite read responder over a flat CSR vector: word-aligns, range-checks, answers
// OKAY/SLVERR, holds R under backpressure and strobes rd_pulse on each successful read.
module axilite_csr_read_data #(
    parameter int          DATA_SIZE    = 128,
    parameter int          ADDR_SIZE    = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          READ_LATENCY = 0,
    parameter logic [1:0]  RESP_OKAY    = 2'd0,
    parameter logic [1:0]  RESP_SLVERR  = 2'd2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] regs,
    axilite_csr_read_data_if.slave bus,
    output logic                 rd_pulse,
    output logic [((DATA_SIZE/DATA_WIDTH) > 1 ? $clog2(DATA_SIZE/DATA_WIDTH) : 1)-1:0] rd_index
);
    localparam int NUM_WORDS = DATA_SIZE / DATA_WIDTH;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int LSB       = $clog2(DATA_WIDTH / 8);
    // Bit address of the last legal word, widened so huge byte addresses cannot wrap into range.
    localparam logic [ADDR_SIZE+2:0] LAST_BIT_ADDR = (ADDR_SIZE+3)'(DATA_SIZE - DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                r_state,    w_state_next;
    logic                  r_arready,  w_arready_next;
    logic                  r_rvalid,   w_rvalid_next;
    logic [DATA_WIDTH-1:0] r_rdata,    w_rdata_next;
    logic [1:0]            r_rresp,    w_rresp_next;
    logic                  r_rd_pulse, w_rd_pulse_next;
    logic [IDX_W-1:0]      r_rd_index, w_rd_index_next;
    logic [3:0]            r_cnt,      w_cnt_next;
    logic [IDX_W-1:0]      r_index,    w_index_next;
    logic                  r_oor,      w_oor_next;

    logic [DATA_WIDTH-1:0] w_words [NUM_WORDS];
    logic [ADDR_SIZE-1:0]  w_word_addr;
    logic [ADDR_SIZE-1:0]  w_aligned;
    logic [ADDR_SIZE+2:0]  w_bit_addr;
    logic                  w_oor;
    logic [IDX_W-1:0]      w_index;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_words
            assign w_words[gi] = regs[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_word_addr = bus.araddr >> LSB;
    assign w_aligned   = w_word_addr << LSB;
    assign w_bit_addr  = {w_aligned, 3'b000};
    assign w_oor       = (w_bit_addr > LAST_BIT_ADDR);
    assign w_index     = w_word_addr[IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rd_pulse <= 1'b0;
            r_rd_index <= '0;
            r_cnt      <= '0;
            r_index    <= '0;
            r_oor      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_arready  <= w_arready_next;
            r_rvalid   <= w_rvalid_next;
            r_rdata    <= w_rdata_next;
            r_rresp    <= w_rresp_next;
            r_rd_pulse <= w_rd_pulse_next;
            r_rd_index <= w_rd_index_next;
            r_cnt      <= w_cnt_next;
            r_index    <= w_index_next;
            r_oor      <= w_oor_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_arready_next  = r_arready;
        w_rvalid_next   = r_rvalid;
        w_rdata_next    = r_rdata;
        w_rresp_next    = r_rresp;
        w_rd_pulse_next = 1'b0;
        w_rd_index_next = r_rd_index;
        w_cnt_next      = r_cnt;
        w_index_next    = r_index;
        w_oor_next      = r_oor;
        case (r_state)
            S_IDLE: begin
                if (bus.arvalid && r_arready) begin
                    w_index_next   = w_index;
                    w_oor_next     = w_oor;
                    w_arready_next = 1'b0;
                    w_cnt_next     = 4'(READ_LATENCY);
                    w_state_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_rdata_next  = r_oor ? '0 : w_words[r_index];
                    w_rresp_next  = r_oor ? RESP_SLVERR : RESP_OKAY;
                    w_rvalid_next = 1'b1;
                    w_state_next  = S_RESP;
                end
            end
            S_RESP: begin
                // Response stays frozen until the master takes it.
                if (bus.rready) begin
                    w_rvalid_next   = 1'b0;
                    w_arready_next  = 1'b1;
                    w_rd_pulse_next = (r_rresp == RESP_OKAY);
                    w_rd_index_next = r_index;
                    w_state_next    = S_IDLE;
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_arready_next = 1'b1;
                w_rvalid_next  = 1'b0;
            end
        endcase
    end

    assign bus.arready = r_arready;
    assign bus.rvalid  = r_rvalid;
    assign bus.rdata   = r_rdata;
    assign bus.rresp   = r_rresp;
    assign rd_pulse    = r_rd_pulse;
    assign rd_index    = r_rd_index;
endmodule

// File: tb/tb_axilite_csr_read_data.sv
// Randomized self-checking bench: one DUT with zero read latency, one with three wait cycles.
module tb_axilite_csr_read_data;
    localparam logic [127:0] BASE = 128'h44444444_33333333_22222222_11111111;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] regs;
    logic         rd_pulse0, rd_pulse1;
    logic [1:0]   rd_index0, rd_index1;
    logic [31:0]  araddr_v  [2];
    logic         arvalid_v [2];
    logic         rready_v  [2];
    int           total = 0;
    int           bad   = 0;

    axilite_csr_read_data_if #(.ADDR_SIZE(32), .DATA_WIDTH(32)) bus0 ();
    axilite_csr_read_data_if #(.ADDR_SIZE(32), .DATA_WIDTH(32)) bus1 ();

    assign bus0.araddr  = araddr_v[0];
    assign bus0.arvalid = arvalid_v[0];
    assign bus0.rready  = rready_v[0];
    assign bus1.araddr  = araddr_v[1];
    assign bus1.arvalid = arvalid_v[1];
    assign bus1.rready  = rready_v[1];

    axilite_csr_read_data #(.DATA_SIZE(128), .ADDR_SIZE(32), .DATA_WIDTH(32), .READ_LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .regs(regs), .bus(bus0), .rd_pulse(rd_pulse0), .rd_index(rd_index0));
    axilite_csr_read_data #(.DATA_SIZE(128), .ADDR_SIZE(32), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst), .regs(regs), .bus(bus1), .rd_pulse(rd_pulse1), .rd_index(rd_index1));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic g_rvalid(int s);        return (s == 1) ? bus1.rvalid  : bus0.rvalid;  endfunction
    function automatic logic g_arready(int s);       return (s == 1) ? bus1.arready : bus0.arready; endfunction
    function automatic logic [31:0] g_rdata(int s);  return (s == 1) ? bus1.rdata   : bus0.rdata;   endfunction
    function automatic logic [1:0] g_rresp(int s);   return (s == 1) ? bus1.rresp   : bus0.rresp;   endfunction
    function automatic logic g_pulse(int s);         return (s == 1) ? rd_pulse1    : rd_pulse0;    endfunction
    function automatic logic [1:0] g_idx(int s);     return (s == 1) ? rd_index1    : rd_index0;    endfunction

    // Full read on one DUT; returns what was observed. Inputs change and outputs are sampled at negedge.
    task automatic do_read(input int s, input logic [31:0] addr, input int stall, input bit scramble,
                           output logic [31:0] d_first, output logic [31:0] d_last, output logic [1:0] resp,
                           output int lat, output logic pulse, output logic [1:0] idx,
                           output logic pulse_after, output logic ar_after);
        @(negedge clk);
        araddr_v[s] = addr; arvalid_v[s] = 1'b1; rready_v[s] = 1'b0;
        @(negedge clk);
        arvalid_v[s] = 1'b0;
        lat = 0;
        while (!g_rvalid(s) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!g_rvalid(s)) begin
            total++; bad++;
            $display("FAIL rvalid_timeout dut%0d addr=%h got rvalid=0 required=1", s, addr);
            d_first = 'x; d_last = 'x; resp = 'x; pulse = 'x; idx = 'x; pulse_after = 'x; ar_after = 'x;
            return;
        end
        d_first = g_rdata(s);
        resp    = g_rresp(s);
        for (int i = 0; i < stall; i++) begin
            if (scramble) regs = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
        end
        rready_v[s] = 1'b1;
        @(negedge clk);
        rready_v[s] = 1'b0;
        pulse    = g_pulse(s);
        idx      = g_idx(s);
        ar_after = g_arready(s);
        d_last   = g_rdata(s);
        @(negedge clk);
        pulse_after = g_pulse(s);
        $display("txn dut%0d addr=%h data=%h resp=%0d lat=%0d pulse=%b idx=%0d", s, addr, d_first, resp, lat, pulse, idx);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        regs = BASE;
        for (int s = 0; s < 2; s++) begin
            araddr_v[s] = '0; arvalid_v[s] = 1'b0; rready_v[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        total++; if (bus0.arready !== 1'b1)   begin bad++; $display("FAIL reset_arready got=%b required=1", bus0.arready); end
        total++; if (bus0.rvalid !== 1'b0)    begin bad++; $display("FAIL reset_rvalid got=%b required=0", bus0.rvalid); end
        total++; if (bus0.rdata !== 32'h0)    begin bad++; $display("FAIL reset_rdata got=%h required=0", bus0.rdata); end
        total++; if (bus0.rresp !== 2'd0)     begin bad++; $display("FAIL reset_rresp got=%0d required=0", bus0.rresp); end
        total++; if (rd_pulse0 !== 1'b0)      begin bad++; $display("FAIL reset_rd_pulse got=%b required=0", rd_pulse0); end
        total++; if (rd_index0 !== 2'd0)      begin bad++; $display("FAIL reset_rd_index got=%0d required=0", rd_index0); end
        total++; if (bus1.arready !== 1'b1)   begin bad++; $display("FAIL reset_arready1 got=%b required=1", bus1.arready); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] df, dl; logic [1:0] rs, ix; int lat; logic p, pa, aa;
        do_read(0, 32'h8, 0, 1'b0, df, dl, rs, lat, p, ix, pa, aa);
        total++; if (lat !== 1)              begin bad++; $display("FAIL basic_latency got=%0d required=1", lat); end
        total++; if (df !== 32'h33333333)    begin bad++; $display("FAIL basic_rdata got=%h required=33333333", df); end
        total++; if (rs !== 2'd0)            begin bad++; $display("FAIL basic_rresp got=%0d required=0", rs); end
        total++; if (p !== 1'b1)             begin bad++; $display("FAIL basic_rd_pulse got=%b required=1", p); end
        total++; if (ix !== 2'd2)            begin bad++; $display("FAIL basic_rd_index got=%0d required=2", ix); end
        total++; if (aa !== 1'b1)            begin bad++; $display("FAIL basic_arready_back got=%b required=1", aa); end
        total++; if (pa !== 1'b0)            begin bad++; $display("FAIL basic_pulse_clear got=%b required=0", pa); end
    endtask

    task automatic test_align_range();
        logic [31:0] df, dl; logic [1:0] rs, ix; int lat; logic p, pa, aa;
        logic [31:0] bad_addr [2];
        do_read(0, 32'h6, 0, 1'b0, df, dl, rs, lat, p, ix, pa, aa);
        total++; if (df !== 32'h22222222)    begin bad++; $display("FAIL align_rdata got=%h required=22222222", df); end
        total++; if (rs !== 2'd0)            begin bad++; $display("FAIL align_rresp got=%0d required=0", rs); end
        total++; if (ix !== 2'd1)            begin bad++; $display("FAIL align_rd_index got=%0d required=1", ix); end
        bad_addr[0] = 32'h10;
        bad_addr[1] = 32'hFFFFFFFC;
        for (int k = 0; k < 2; k++) begin
            do_read(0, bad_addr[k], 1, 1'b0, df, dl, rs, lat, p, ix, pa, aa);
            total++; if (rs !== 2'd2)         begin bad++; $display("FAIL range_rresp addr=%h got=%0d required=2", bad_addr[k], rs); end
            total++; if (df !== 32'h0)        begin bad++; $display("FAIL range_rdata addr=%h got=%h required=0", bad_addr[k], df); end
            total++; if (p !== 1'b0)          begin bad++; $display("FAIL range_no_pulse addr=%h got=%b required=0", bad_addr[k], p); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] df, dl; logic [1:0] rs, ix; int lat, n; logic p, pa, aa;
        regs = BASE;
        @(negedge clk);
        araddr_v[0] = 32'hC; arvalid_v[0] = 1'b1; rready_v[0] = 1'b0;
        @(negedge clk);
        arvalid_v[0] = 1'b0;
        n = 0;
        while (!bus0.rvalid && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) regs[127:96] = 32'hDEADBEEF;
            if (i == 2) begin araddr_v[0] = 32'h0; arvalid_v[0] = 1'b1; end
            if (i == 3) arvalid_v[0] = 1'b0;
            @(negedge clk);
            total++; if (bus0.rvalid !== 1'b1)       begin bad++; $display("FAIL bp_rvalid cyc=%0d got=%b required=1", i, bus0.rvalid); end
            total++; if (bus0.rdata !== 32'h44444444) begin bad++; $display("FAIL bp_rdata cyc=%0d got=%h required=44444444", i, bus0.rdata); end
            total++; if (bus0.arready !== 1'b0)      begin bad++; $display("FAIL bp_arready cyc=%0d got=%b required=0", i, bus0.arready); end
        end
        rready_v[0] = 1'b1;
        @(negedge clk);
        rready_v[0] = 1'b0;
        total++; if (bus0.rvalid !== 1'b0)  begin bad++; $display("FAIL bp_done_rvalid got=%b required=0", bus0.rvalid); end
        total++; if (rd_pulse0 !== 1'b1)    begin bad++; $display("FAIL bp_pulse got=%b required=1", rd_pulse0); end
        total++; if (rd_index0 !== 2'd3)    begin bad++; $display("FAIL bp_index got=%0d required=3", rd_index0); end
        $display("txn dut0 addr=0000000c backpressure held data=%h", bus0.rdata);
        @(negedge clk);
        do_read(0, 32'hC, 0, 1'b0, df, dl, rs, lat, p, ix, pa, aa);
        total++; if (df !== 32'hDEADBEEF)   begin bad++; $display("FAIL bp_reread got=%h required=deadbeef", df); end
    endtask

    task automatic test_latency3();
        int n;
        regs = BASE;
        @(negedge clk);
        araddr_v[1] = 32'h4; arvalid_v[1] = 1'b1; rready_v[1] = 1'b0;
        @(negedge clk);
        arvalid_v[1] = 1'b0;
        n = 0;
        while (!bus1.rvalid && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) regs[63:32] = 32'hCAFEF00D;
        end
        total++; if (n !== 4)                   begin bad++; $display("FAIL lat3_edges got=%0d required=4", n); end
        total++; if (bus1.rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL lat3_rdata got=%h required=cafef00d", bus1.rdata); end
        rready_v[1] = 1'b1;
        @(negedge clk);
        rready_v[1] = 1'b0;
        total++; if (rd_pulse1 !== 1'b1)        begin bad++; $display("FAIL lat3_pulse got=%b required=1", rd_pulse1); end
        total++; if (rd_index1 !== 2'd1)        begin bad++; $display("FAIL lat3_index got=%0d required=1", rd_index1); end
        $display("txn dut1 addr=00000004 data=%h edges=%0d", bus1.rdata, n);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] df, dl; logic [1:0] rs, ix; int lat; logic p, pa, aa;
        regs = BASE;
        @(negedge clk);
        araddr_v[0] = 32'h4; arvalid_v[0] = 1'b1; rready_v[0] = 1'b0;
        araddr_v[1] = 32'h8; arvalid_v[1] = 1'b1; rready_v[1] = 1'b0;
        @(negedge clk);
        arvalid_v[0] = 1'b0; arvalid_v[1] = 1'b0;
        @(negedge clk);
        total++; if (bus0.rvalid !== 1'b1)  begin bad++; $display("FAIL rstmid_pre_resp got=%b required=1", bus0.rvalid); end
        total++; if (bus1.arready !== 1'b0) begin bad++; $display("FAIL rstmid_pre_wait got=%b required=0", bus1.arready); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus0.rvalid !== 1'b0)  begin bad++; $display("FAIL rstmid_rvalid0 got=%b required=0", bus0.rvalid); end
        total++; if (bus0.arready !== 1'b1) begin bad++; $display("FAIL rstmid_arready0 got=%b required=1", bus0.arready); end
        total++; if (bus1.rvalid !== 1'b0)  begin bad++; $display("FAIL rstmid_rvalid1 got=%b required=0", bus1.rvalid); end
        total++; if (bus1.arready !== 1'b1) begin bad++; $display("FAIL rstmid_arready1 got=%b required=1", bus1.arready); end
        rready_v[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rready_v[0] = 1'b0;
        total++; if (rd_pulse0 !== 1'b0)    begin bad++; $display("FAIL rstmid_pulse0 got=%b required=0", rd_pulse0); end
        total++; if (rd_pulse1 !== 1'b0)    begin bad++; $display("FAIL rstmid_pulse1 got=%b required=0", rd_pulse1); end
        do_read(0, 32'h0, 0, 1'b0, df, dl, rs, lat, p, ix, pa, aa);
        total++; if (df !== 32'h11111111)   begin bad++; $display("FAIL rstmid_read0 got=%h required=11111111", df); end
        total++; if (p !== 1'b1)            begin bad++; $display("FAIL rstmid_read0_pulse got=%b required=1", p); end
        do_read(1, 32'h0, 0, 1'b0, df, dl, rs, lat, p, ix, pa, aa);
        total++; if (df !== 32'h11111111 || lat !== 4) begin bad++; $display("FAIL rstmid_read1 got=%h/%0d required=11111111/4", df, lat); end
    endtask

    // Reference: byte address / 4 selects a word; only words 0..3 exist.
    task automatic test_random();
        logic [31:0] df, dl, addr, exp_d; logic [1:0] rs, ix, exp_ix; int lat, s, stall, exp_lat; logic p, pa, aa, exp_ok;
        longint unsigned word;
        for (int it = 0; it < 40; it++) begin
            regs  = {$urandom(), $urandom(), $urandom(), $urandom()};
            s     = int'($urandom_range(0, 1));
            stall = int'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       addr = $urandom_range(0, 15);
                1:       addr = $urandom_range(16, 64);
                default: addr = $urandom();
            endcase
            word    = longint'(addr) / 4;
            exp_ok  = (word < 4);
            exp_d   = exp_ok ? regs[int'(word)*32 +: 32] : 32'h0;
            exp_ix  = word[1:0];
            exp_lat = (s == 1) ? 4 : 1;
            do_read(s, addr, stall, 1'b1, df, dl, rs, lat, p, ix, pa, aa);
            total++; if (df !== exp_d)  begin bad++; $display("FAIL rnd_rdata it=%0d addr=%h got=%h required=%h", it, addr, df, exp_d); end
            total++; if (dl !== exp_d)  begin bad++; $display("FAIL rnd_hold it=%0d got=%h required=%h", it, dl, exp_d); end
            total++; if (rs !== (exp_ok ? 2'd0 : 2'd2)) begin bad++; $display("FAIL rnd_rresp it=%0d got=%0d required=%0d", it, rs, exp_ok ? 0 : 2); end
            total++; if (p !== exp_ok)  begin bad++; $display("FAIL rnd_pulse it=%0d got=%b required=%b", it, p, exp_ok); end
            total++; if (lat !== exp_lat) begin bad++; $display("FAIL rnd_latency it=%0d got=%0d required=%0d", it, lat, exp_lat); end
            total++; if (pa !== 1'b0 || aa !== 1'b1) begin bad++; $display("FAIL rnd_post it=%0d pulse=%b arready=%b required 0/1", it, pa, aa); end
            if (exp_ok) begin
                total++; if (ix !== exp_ix) begin bad++; $display("FAIL rnd_index it=%0d got=%0d required=%0d", it, ix, exp_ix); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_align_range();
        test_backpressure();
        test_latency3();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
